multicycle_control_fsm: RTL and testbench
=========================================

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 Parameter INSTR_WIDTH, default 32: width of the Instruction input.
REQ-002 CLK  in  1  single clock; all state changes on rising edge.
REQ-003 RST  in  1  reset, asynchronous, active-high.
REQ-004 Instruction  in  INSTR_WIDTH  registered instruction word; OpCode=[31:26], Funct=[5:0].
REQ-005 Zero  in  1  ALU zero flag.
REQ-006 IorD  out  1  memory address select (0 PC, 1 ALUOut).
REQ-007 MemWrite  out  1  data memory write enable.
REQ-008 IRWrite  out  1  instruction register load enable.
REQ-009 PCEn  out  1  PC load enable = PCWrite | (Branch & Zero).
REQ-010 RegDst  out  1  destination select (0 rt, 1 rd).
REQ-011 MemtoReg  out  1  writeback select (0 ALUOut, 1 memory data).
REQ-012 RegWrite  out  1  register file write enable.
REQ-013 ALUSrcA  out  1  ALU A select (0 PC, 1 register A).
REQ-014 ALUSrcB  out  2  ALU B select (00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2).
REQ-015 ALUControl  out  3  ALU operation code.
REQ-016 PCSrc  out  2  next-PC select (00 ALU result, 01 ALUOut, 10 jump target).
REQ-017 InstrDone  out  1  high during the final state of each instruction.

Function
REQ-018 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP; 4-bit encoding.
REQ-019 FETCH -> DECODE unconditionally; FETCH drives IorD=0, IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=01, ADD, PCSrc=00.
REQ-020 DECODE: ALUSrcA=0, ALUSrcB=11, ADD; next by OpCode: 000000 EXECUTE, 100011/101011 MEMADR, 001000 ADDIEXEC, 000100 BRANCH, 000010 JUMP, other FETCH.
REQ-021 MEMADR: ALUSrcA=1, ALUSrcB=10, ADD; -> MEMRD if lw, MEMWR if sw.
REQ-022 MEMRD: IorD=1 -> MEMWB; MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
REQ-023 MEMWR: IorD=1, MemWrite=1 -> FETCH.
REQ-024 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct -> ALUWB; ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
REQ-025 ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ADD -> ADDIWB; ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
REQ-026 BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01, Branch=1 -> FETCH.
REQ-027 JUMP: PCSrc=10, PCWrite=1 -> FETCH.
REQ-028 Latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2 (no write asserted).
REQ-029 ALUControl codes: AND 000, OR 001, ADD 010, SUB 100, SLT 110, MUL 101; Funct 100100/100101/100000/100010/101010/011100 respectively; unknown Funct -> 000.
REQ-030 Outputs are Moore (decoded from state) except PCEn, which also depends combinationally on Zero; unlisted outputs are 0.
REQ-031 InstrDone=1 in MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP, and in DECODE for illegal OpCode.
REQ-032 Instruction is sampled only in DECODE and MEMADR; changes in other states have no effect.

Reset
REQ-033 RST high forces state to FETCH immediately, independent of CLK, including mid-instruction.
REQ-034 While RST high, IRWrite, PCEn, MemWrite, RegWrite and InstrDone are 0; other outputs take FETCH values.
REQ-035 First rising CLK after RST deasserts is a normal FETCH cycle.

Structure
REQ-036 State encodings, OpCode constants, Funct constants and ALUControl codes reside in the shared MIPS definitions package.
REQ-037 Funct-to-ALUControl decode is one combinational sub-module, mc_alu_decoder; the FSM and output decode stay in the top.

Verification
REQ-038 lw (OpCode 100011): states FETCH,DECODE,MEMADR,MEMRD,MEMWB; RegWrite=1, MemtoReg=1 only in cycle 5.
REQ-039 beq with Zero=1 then Zero=0: PCEn=1 in BRANCH with PCSrc=01 for the first, PCEn=0 for the second; 3 cycles each.
REQ-040 R-type Funct 101010: ALUControl=110 in EXECUTE, RegDst=1, RegWrite=1 in ALUWB.
REQ-041 OpCode 111111: DECODE -> FETCH, InstrDone=1 in DECODE, no RegWrite/MemWrite pulse.
REQ-042 RST asserted mid-MEMWR, between edges: MemWrite drops to 0 at once, state FETCH; resumes fetch after release.
REQ-043 j (OpCode 000010) followed by sw: PCSrc=10, PCEn=1 in JUMP; sw shows MemWrite=1, IorD=1 only in cycle 4.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared MIPS definitions for the multicycle controller: state encodings,
// opcode and funct fields, and ALU operation codes.
package multicycle_control_fsm_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEXEC = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JUMP     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;
   localparam logic [5:0] FUNCT_MUL = 6'b011100;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b110;
   localparam logic [2:0] ALU_MUL = 3'b101;

   function automatic logic is_known_op(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_ADDI) || (op == OP_BEQ) || (op == OP_J);
   endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational Funct-to-ALUControl decode for R-type instructions;
// unrecognised Funct values fall back to AND.
module mc_alu_decoder
   import multicycle_control_fsm_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALU_AND;
      case (funct)
         FUNCT_AND: alu_control = ALU_AND;
         FUNCT_OR:  alu_control = ALU_OR;
         FUNCT_ADD: alu_control = ALU_ADD;
         FUNCT_SUB: alu_control = ALU_SUB;
         FUNCT_SLT: alu_control = ALU_SLT;
         FUNCT_MUL: alu_control = ALU_MUL;
         default:   alu_control = ALU_AND;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch, decode and the
// per-instruction execute/memory/writeback steps.
module multicycle_control_fsm
   import multicycle_control_fsm_pkg::*;
#(
   parameter int INSTR_WIDTH = 32
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [INSTR_WIDTH-1:0] Instruction,
   input  logic                   Zero,
   output logic                   IorD,
   output logic                   MemWrite,
   output logic                   IRWrite,
   output logic                   PCEn,
   output logic                   RegDst,
   output logic                   MemtoReg,
   output logic                   RegWrite,
   output logic                   ALUSrcA,
   output logic [1:0]             ALUSrcB,
   output logic [2:0]             ALUControl,
   output logic [1:0]             PCSrc,
   output logic                   InstrDone
);

   state_t     state, next_state;
   logic [5:0] opcode, funct, funct_q;
   logic [2:0] rtype_alu;
   logic       pc_write, branch, ir_write, mem_write, reg_write, instr_done;
   logic       unused_instr;

   assign opcode       = Instruction[31:26];
   assign funct        = Instruction[5:0];
   assign unused_instr = ^Instruction;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= S_FETCH;
      else     state <= next_state;
   end

   // Funct is captured in DECODE so EXECUTE is immune to later IR changes.
   always_ff @(posedge CLK) begin
      if (state == S_DECODE) funct_q <= funct;
   end

   mc_alu_decoder u_alu_decoder (
      .funct       (funct_q),
      .alu_control (rtype_alu)
   );

   always_comb begin
      next_state = S_FETCH;
      IorD       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      reg_write  = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUControl = ALU_AND;
      PCSrc      = 2'b00;
      instr_done = 1'b0;
      case (state)
         S_FETCH: begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            ALUSrcB    = 2'b01;
            ALUControl = ALU_ADD;
            next_state = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcB    = 2'b11;
            ALUControl = ALU_ADD;
            instr_done = !is_known_op(opcode);
            case (opcode)
               OP_RTYPE:     next_state = S_EXECUTE;
               OP_LW, OP_SW: next_state = S_MEMADR;
               OP_ADDI:      next_state = S_ADDIEXEC;
               OP_BEQ:       next_state = S_BRANCH;
               OP_J:         next_state = S_JUMP;
               default:      next_state = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            ALUControl = ALU_ADD;
            next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            IorD       = 1'b1;
            next_state = S_MEMWB;
         end
         S_MEMWB: begin
            MemtoReg   = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWR: begin
            IorD       = 1'b1;
            mem_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_EXECUTE: begin
            ALUSrcA    = 1'b1;
            ALUControl = rtype_alu;
            next_state = S_ALUWB;
         end
         S_ALUWB: begin
            RegDst     = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_ADDIEXEC: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            ALUControl = ALU_ADD;
            next_state = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA    = 1'b1;
            ALUControl = ALU_SUB;
            PCSrc      = 2'b01;
            branch     = 1'b1;
            instr_done = 1'b1;
         end
         S_JUMP: begin
            PCSrc      = 2'b10;
            pc_write   = 1'b1;
            instr_done = 1'b1;
         end
         default: next_state = S_FETCH;
      endcase
   end

   // Write strobes are masked while RST is held; the rest show FETCH values.
   assign IRWrite   = ir_write  & ~RST;
   assign MemWrite  = mem_write & ~RST;
   assign RegWrite  = reg_write & ~RST;
   assign InstrDone = instr_done & ~RST;
   assign PCEn      = (pc_write | (branch & Zero)) & ~RST;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: directed instruction sequences
// queue hand-computed per-cycle output vectors, a monitor pops and compares.
module tb_multicycle_control_fsm;

   logic        CLK, RST, Zero;
   logic [31:0] Instruction;
   logic        IorD, MemWrite, IRWrite, PCEn, RegDst, MemtoReg, RegWrite, ALUSrcA;
   logic [1:0]  ALUSrcB, PCSrc;
   logic [2:0]  ALUControl;
   logic        InstrDone;

   multicycle_control_fsm #(.INSTR_WIDTH(32)) dut (
      .CLK(CLK), .RST(RST), .Instruction(Instruction), .Zero(Zero),
      .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCEn(PCEn),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
      .PCSrc(PCSrc), .InstrDone(InstrDone)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [15:0] vec;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   checks = 0;
   int   passes = 0;
   event chk_ev;

   logic [15:0] outv;
   assign outv = {IorD, MemWrite, IRWrite, PCEn, RegDst, MemtoReg, RegWrite, ALUSrcA,
                  ALUSrcB, ALUControl, PCSrc, InstrDone};

   // Field order: IorD MemWrite IRWrite PCEn RegDst MemtoReg RegWrite ALUSrcA ALUSrcB ALUControl PCSrc InstrDone
   function automatic logic [15:0] v(input logic iord, mw, irw, pcen, rd, m2r, rw, asa,
                                     input logic [1:0] asb, input logic [2:0] alu,
                                     input logic [1:0] pcs, input logic done);
      return {iord, mw, irw, pcen, rd, m2r, rw, asa, asb, alu, pcs, done};
   endfunction

   always @(negedge CLK or chk_ev) begin
      if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         checks++;
         if (outv === cur.vec) passes++;
         else $display("FAIL %s: got %h expected %h", cur.name, outv, cur.vec);
      end
   end

   task automatic step(input logic [31:0] ins, input logic z, input logic [15:0] e,
                       input string nm);
      Instruction = ins;
      Zero        = z;
      exp_q.push_back('{e, nm});
      @(posedge CLK);
      #1;
   endtask

   localparam logic [31:0] GARB    = 32'hAC00_0024;
   localparam logic [31:0] I_LW    = 32'h8C22_0004;
   localparam logic [31:0] I_SW    = 32'hAC22_0008;
   localparam logic [31:0] I_SLT   = 32'h0043_082A;
   localparam logic [31:0] I_MUL   = 32'h0043_081C;
   localparam logic [31:0] I_BADF  = 32'h0043_083F;
   localparam logic [31:0] I_ADD   = 32'h0043_0820;
   localparam logic [31:0] I_ADDI  = 32'h2022_0005;
   localparam logic [31:0] I_BEQ   = 32'h1022_0003;
   localparam logic [31:0] I_J     = 32'h0800_0010;
   localparam logic [31:0] I_ILL   = 32'hFC00_0000;

   logic [15:0] e_reset, e_fetch, e_decode, e_decode_ill, e_memadr, e_memrd, e_memwb;
   logic [15:0] e_memwr, e_aluwb, e_addiex, e_addiwb, e_jump;

   initial begin
      e_reset      = v(0,0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0);
      e_fetch      = v(0,0,1,1,0,0,0,0,2'b01,3'b010,2'b00,0);
      e_decode     = v(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0);
      e_decode_ill = v(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,1);
      e_memadr     = v(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0);
      e_memrd      = v(1,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0);
      e_memwb      = v(0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,1);
      e_memwr      = v(1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,1);
      e_aluwb      = v(0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,1);
      e_addiex     = v(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0);
      e_addiwb     = v(0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00,1);
      e_jump       = v(0,0,0,1,0,0,0,0,2'b00,3'b000,2'b10,1);

      RST = 1'b1;
      Zero = 1'b0;
      Instruction = GARB;
      @(posedge CLK);
      #1;
      step(GARB, 1'b0, e_reset, "reset_hold");
      RST = 1'b0;

      // lw, with the IR disturbed outside DECODE/MEMADR
      step(GARB,  1'b0, e_fetch,  "lw_fetch");
      step(I_LW,  1'b0, e_decode, "lw_decode");
      step(I_LW,  1'b0, e_memadr, "lw_memadr");
      step(GARB,  1'b0, e_memrd,  "lw_memrd");
      step(GARB,  1'b0, e_memwb,  "lw_memwb");

      // beq taken, Zero high in DECODE must not raise PCEn
      step(I_BEQ, 1'b1, e_fetch,  "beq1_fetch");
      step(I_BEQ, 1'b1, e_decode, "beq1_decode");
      step(I_BEQ, 1'b1, v(0,0,0,1,0,0,0,1,2'b00,3'b100,2'b01,1), "beq1_branch");
      step(I_BEQ, 1'b0, e_fetch,  "beq0_fetch");
      step(I_BEQ, 1'b0, e_decode, "beq0_decode");
      step(I_BEQ, 1'b0, v(0,0,0,0,0,0,0,1,2'b00,3'b100,2'b01,1), "beq0_branch");

      // R-type slt, funct disturbed during EXECUTE
      step(I_SLT, 1'b0, e_fetch,  "slt_fetch");
      step(I_SLT, 1'b0, e_decode, "slt_decode");
      step(GARB,  1'b0, v(0,0,0,0,0,0,0,1,2'b00,3'b110,2'b00,0), "slt_execute");
      step(GARB,  1'b0, e_aluwb,  "slt_aluwb");

      step(I_MUL, 1'b0, e_fetch,  "mul_fetch");
      step(I_MUL, 1'b0, e_decode, "mul_decode");
      step(I_MUL, 1'b0, v(0,0,0,0,0,0,0,1,2'b00,3'b101,2'b00,0), "mul_execute");
      step(I_MUL, 1'b0, e_aluwb,  "mul_aluwb");

      step(I_BADF, 1'b0, e_fetch,  "badf_fetch");
      step(I_BADF, 1'b0, e_decode, "badf_decode");
      step(I_BADF, 1'b0, v(0,0,0,0,0,0,0,1,2'b00,3'b000,2'b00,0), "badf_execute");
      step(I_BADF, 1'b0, e_aluwb,  "badf_aluwb");

      step(I_ADDI, 1'b0, e_fetch,  "addi_fetch");
      step(I_ADDI, 1'b0, e_decode, "addi_decode");
      step(I_ADDI, 1'b0, e_addiex, "addi_exec");
      step(I_ADDI, 1'b0, e_addiwb, "addi_wb");

      // illegal opcode: two cycles, no write strobes
      step(I_ILL, 1'b0, e_fetch,      "ill_fetch");
      step(I_ILL, 1'b0, e_decode_ill, "ill_decode");

      // j followed by sw
      step(I_J,  1'b0, e_fetch,  "j_fetch");
      step(I_J,  1'b0, e_decode, "j_decode");
      step(I_J,  1'b0, e_jump,   "j_jump");
      step(I_SW, 1'b0, e_fetch,  "sw_fetch");
      step(I_SW, 1'b0, e_decode, "sw_decode");
      step(I_SW, 1'b0, e_memadr, "sw_memadr");
      step(GARB, 1'b0, e_memwr,  "sw_memwr");

      // sw interrupted by reset in the middle of MEMWR
      step(I_SW, 1'b0, e_fetch,  "swr_fetch");
      step(I_SW, 1'b0, e_decode, "swr_decode");
      step(I_SW, 1'b0, e_memadr, "swr_memadr");
      Instruction = GARB;
      exp_q.push_back('{e_memwr, "swr_memwr"});
      @(negedge CLK);
      #1;
      RST = 1'b1;
      #1;
      exp_q.push_back('{e_reset, "swr_rst_async"});
      -> chk_ev;
      @(posedge CLK);
      #1;
      step(GARB, 1'b0, e_reset, "swr_rst_held");
      RST = 1'b0;

      step(I_ADD, 1'b0, e_fetch,  "resume_fetch");
      step(I_ADD, 1'b0, e_decode, "resume_decode");
      step(I_ADD, 1'b0, v(0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0), "resume_execute");
      step(I_ADD, 1'b0, e_aluwb,  "resume_aluwb");
      step(I_ADD, 1'b0, e_fetch,  "resume_next_fetch");

      begin
         int n;
         n = 0;
         while (exp_q.size() > 0 && n < 20) begin
            @(negedge CLK);
            n++;
         end
         if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
         end
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
